// File: rtl/iter_shift.sv
// Iterative 32-bit shifter (SLL/SRL/SRA): up to STEP bit positions per clock, ceil(amt/STEP)+1 edges from accept to result.
// Accepts a request only in IDLE; holds the result in DONE until res_ready_i, and flush_i aborts at any point.
module iter_shift #(
  parameter int STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_o,
  output logic        res_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_t;

  localparam logic [4:0] LP_STEP = 5'(STEP);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_val;
  logic [4:0]  r_rem;
  op_t         r_op;
  logic        r_err;
  logic        r_sign;

  logic        w_accept;
  logic        w_legal;
  op_t         w_op_in;
  logic [4:0]  w_k;
  logic [4:0]  w_rem_nxt;
  logic [31:0] w_fill_mask;
  logic [31:0] w_shifted;
  logic        w_retire;
  logic        w_unused_op2;

  assign w_unused_op2 = ^op2_i[31:5];

  // Request decode
  assign w_accept = req_valid_i && (r_state == S_IDLE);
  assign w_legal  = (funct3_i == 3'b001) || (funct3_i == 3'b101);

  always_comb begin
    w_op_in = OP_SLL;
    if (funct3_i == 3'b101) begin
      w_op_in = funct7_i ? OP_SRA : OP_SRL;
    end
  end

  // One iteration of the shifter: k = min(remaining, STEP)
  assign w_k         = (r_rem > LP_STEP) ? LP_STEP : r_rem;
  assign w_rem_nxt   = r_rem - w_k;
  assign w_fill_mask = ~(32'hFFFF_FFFF >> w_k);

  always_comb begin
    w_shifted = r_val;
    case (r_op)
      OP_SLL:  w_shifted = r_val << w_k;
      OP_SRL:  w_shifted = r_val >> w_k;
      OP_SRA:  w_shifted = (r_val >> w_k) | (r_sign ? w_fill_mask : 32'h0);
      default: w_shifted = r_val;
    endcase
  end

  assign w_retire = (r_state == S_DONE) && res_ready_i;

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            w_state_nxt = (w_legal && (op2_i[4:0] != 5'd0)) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          if (w_rem_nxt == 5'd0) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand/working registers; cleared when an operation ends so IDLE holds zeros
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_val  <= 32'h0;
      r_rem  <= 5'd0;
      r_op   <= OP_SLL;
      r_err  <= 1'b0;
      r_sign <= 1'b0;
    end else if (flush_i || w_retire) begin
      r_val  <= 32'h0;
      r_rem  <= 5'd0;
      r_op   <= OP_SLL;
      r_err  <= 1'b0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_val  <= w_legal ? op1_i : 32'h0;
      r_rem  <= w_legal ? op2_i[4:0] : 5'd0;
      r_op   <= w_op_in;
      r_err  <= ~w_legal;
      r_sign <= op1_i[31];
    end else if (r_state == S_SHIFT) begin
      r_val <= w_shifted;
      r_rem <= w_rem_nxt;
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign res_valid_o = (r_state == S_DONE);
  assign res_o       = (r_state == S_DONE && !r_err) ? r_val : 32'h0;
  assign res_err_o   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_iter_shift.sv
// Directed plus randomized bench for iter_shift with an arithmetic reference model.
module tb_iter_shift;
  localparam int STEP = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  funct3_i = 3'b000;
  logic        funct7_i = 1'b0;
  logic [31:0] op1_i = 32'h0;
  logic [31:0] op2_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_o;
  logic        res_err_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  iter_shift #(.STEP(STEP)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .flush_i     (flush_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o),
    .res_err_o   (res_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic f7);
    int amt;
    amt = int'(b[4:0]);
    case (f3)
      3'b001:  return a << amt;
      3'b101:  return f7 ? 32'($signed(a) >>> amt) : (a >> amt);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic [2:0] f3);
    int amt;
    amt = int'(b[4:0]);
    if (!is_legal(f3) || amt == 0) return 1;
    return (amt + STEP - 1) / STEP + 1;
  endfunction

  // Issue one request, measure latency, optionally stall the consumer, then retire.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7, input int hold);
    int edges;
    logic [31:0] exp_res;
    exp_res = model_res(a, b, f3, f7);
    @(negedge clk_i);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    op1_i = a; op2_i = b; funct3_i = f3; funct7_i = f7;
    res_ready_i = (hold == 0);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    op1_i = $urandom; op2_i = $urandom; funct3_i = 3'($urandom); funct7_i = 1'($urandom);
    edges = 1;
    while (!res_valid_o && edges < 100) begin
      check({tag, "_idle_res"}, res_o, 32'h0);
      @(posedge clk_i);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), 32'(model_lat(b, f3)));
    check({tag, "_res"}, res_o, exp_res);
    check({tag, "_err"}, 32'(res_err_o), 32'(!is_legal(f3)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      check({tag, "_hold_vld"}, 32'(res_valid_o), 32'd1);
      check({tag, "_hold_res"}, res_o, exp_res);
      check({tag, "_hold_rdy"}, 32'(req_ready_o), 32'd0);
      if (i == hold - 1) res_ready_i = 1'b1;
    end
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    check({tag, "_retired"}, 32'(res_valid_o), 32'd0);
    check({tag, "_post_res"}, res_o, 32'h0);
    check({tag, "_post_rdy"}, 32'(req_ready_o), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      check({tag, "_no_vld"}, 32'(res_valid_o), 32'd0);
      check({tag, "_no_busy"}, 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] f3;
    // Reset state
    #3;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_vld", 32'(res_valid_o), 32'd0);
    check("rst_res", res_o, 32'h0);
    check("rst_err", 32'(res_err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    run_op("sll31", 32'h0000_0001, 32'd31, 3'b001, 1'b0, 0);
    run_op("sra4", 32'h8000_0000, 32'd4, 3'b101, 1'b1, 0);
    run_op("srl4", 32'h8000_0000, 32'd4, 3'b101, 1'b0, 0);
    run_op("srl_wrap", 32'h8000_0000, 32'h0000_0021, 3'b101, 1'b0, 0);
    run_op("amt0", 32'hDEAD_BEEF, 32'd0, 3'b101, 1'b1, 0);
    run_op("stall5", 32'h1234_5678, 32'd9, 3'b001, 1'b1, 5);
    run_op("illegal", 32'hFFFF_FFFF, 32'd7, 3'b000, 1'b0, 0);
    run_op("sra31", 32'h8000_0001, 32'd31, 3'b101, 1'b1, 2);

    // Async reset during SHIFT
    @(negedge clk_i);
    req_valid_i = 1'b1; op1_i = 32'h1; op2_i = 32'd31; funct3_i = 3'b001; funct7_i = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(req_ready_o), 32'd1);
    check("midrst_vld", 32'(res_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    expect_quiet("after_rst", 12);

    // Flush during SHIFT
    @(negedge clk_i);
    req_valid_i = 1'b1; op1_i = 32'h1; op2_i = 32'd31; funct3_i = 3'b001;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("flush_busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    expect_quiet("after_flush", 12);

    // Flush has priority over accept
    @(negedge clk_i);
    req_valid_i = 1'b1; flush_i = 1'b1; op1_i = 32'h5; op2_i = 32'd0; funct3_i = 3'b001;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_vs_accept", 32'(busy_o), 32'd0);

    run_op("sll3by2", 32'h0000_0003, 32'd2, 3'b001, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    f3 = 3'b001;
        2, 3:    f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      run_op("rand", $urandom, $urandom, f3, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iter_shift.md
ITER_SHIFT -- requirements
Module: iter_shift

Interface
REQ-001 Parameter STEP, default 4, meaning: maximum bit positions shifted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  block can accept a request.
REQ-006 funct3_i  input  3  shift opcode; 3'b001 SLL, 3'b101 SRL/SRA.
REQ-007 funct7_i  input  1  instruction bit 30; 1 selects SRA when funct3_i=3'b101.
REQ-008 op1_i  input  32  value to shift.
REQ-009 op2_i  input  32  shift amount; only op2_i[4:0] is used.
REQ-010 flush_i  input  1  synchronous abort of the in-flight operation.
REQ-011 res_valid_o  output  1  result available.
REQ-012 res_ready_i  input  1  consumer accepts the result.
REQ-013 res_o  output  32  shift result.
REQ-014 res_err_o  output  1  qualifies res_o; 1 = illegal funct3_i.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states are IDLE, SHIFT and DONE.
REQ-017 req_ready_o is high only in IDLE; a request is accepted on an edge where req_valid_i and req_ready_o are both high.
REQ-018 Accept captures op1_i, shift amount op2_i[4:0], operation type (SLL, SRL, SRA) and error status into internal registers; the input ports are not sampled again.
REQ-019 Accept with legal funct3_i and nonzero amount moves IDLE->SHIFT; amount 0 or illegal funct3_i moves IDLE->DONE.
REQ-020 Each edge in SHIFT shifts the working value by k=min(remaining,STEP) and subtracts k from remaining; when remaining reaches 0, SHIFT->DONE.
REQ-021 SLL and SRL fill vacated bits with 0; SRA fills vacated bits with the captured op1 bit 31.
REQ-022 res_valid_o is high exactly in DONE; the transition from accept to res_valid_o high takes ceil(amount/STEP)+1 edges (1 edge for amount 0).
REQ-023 In DONE, res_o and res_err_o stay stable until res_valid_o and res_ready_i are both high on an edge, which moves DONE->IDLE.
REQ-024 No new request is accepted on the DONE->IDLE edge; the earliest following accept is on the next edge.
REQ-025 Illegal funct3_i (anything other than 001 or 101): res_o=0 and res_err_o=1 in DONE; funct7_i is ignored for SLL.
REQ-026 flush_i high on an edge forces IDLE and discards the operation; flush_i has priority over accept, shift and result handshake.
REQ-027 res_o is 0 and res_err_o is 0 whenever res_valid_o is low.

Reset
REQ-028 While rst_i is high, state is IDLE, req_ready_o=1, res_valid_o=0, res_o=0, res_err_o=0, busy_o=0, and internal registers are 0.
REQ-029 rst_i asserted mid-operation, in SHIFT or DONE, abandons the operation immediately without waiting for a clock edge; no result is presented after rst_i is released.
REQ-030 The first request accepted after rst_i deasserts completes normally.

Verification
REQ-031 STEP=4, SLL op1=0x0000_0001 op2=31, res_ready_i=1 -> res_valid_o high 9 edges after accept, res_o=0x8000_0000, res_err_o=0.
REQ-032 STEP=4, SRA (funct7_i=1) op1=0x8000_0000 op2=4 -> res_o=0xF800_0000 after 2 edges; the same request as SRL (funct7_i=0) -> res_o=0x0800_0000.
REQ-033 SRL op1=0x8000_0000 op2=0x0000_0021 -> amount 1, res_o=0x4000_0000; op2=0 -> res_o=op1 after 1 edge.
REQ-034 res_ready_i held low for 5 cycles in DONE -> res_o and res_valid_o stable and req_ready_o low throughout; the result retires on the first edge with res_ready_i high.
REQ-035 funct3_i=3'b000 -> DONE after 1 edge with res_err_o=1 and res_o=0.
REQ-036 rst_i pulsed, then separately flush_i pulsed, during SHIFT of an SLL by 31 -> IDLE with res_valid_o never asserted; the next SLL 0x3 by 2 returns 0x0000_000C.
